// File: rtl/grant_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// grant_sequencer_pkg
//
// Purpose:
//   Shared definitions for the grant sequencer slice: the sequencer state
//   encoding and the default client count / burst-length field width used
//   as parameter defaults by grant_sequencer and beat_counter.
//
// Contents:
//   DEFAULT_N    - default number of requesting clients (arbiter width)
//   DEFAULT_LW   - default width of the burst-length field
//   seq_state_t  - sequencer state encoding (IDLE, BUSY, DONE)
// ---------------------------------------------------------------------------
package grant_sequencer_pkg;

  localparam int DEFAULT_N  = 4;
  localparam int DEFAULT_LW = 4;

  // IDLE: waiting for a grant from the external arbiter
  // BUSY: burst beats in progress, counter walking down to zero
  // DONE: single-cycle completion, done pulse on the owner bit
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/grant_sequencer_beat_counter.sv
// ---------------------------------------------------------------------------
// beat_counter
//
// Purpose:
//   Down-counter that tracks the remaining beats of the current burst.
//   It is loaded with the accepted burst length and then decremented once
//   per BUSY cycle. The counter saturates at zero so that an all-ones
//   burst length yields exactly 2^LW beats and never wraps.
//
// Ports:
//   clk       in   clock, all updates on the rising edge
//   rst_n     in   synchronous active-low reset, clears the count
//   load      in   load load_val into the counter (has priority over dec)
//   dec       in   decrement by one when the count is non-zero
//   load_val  in   LW-bit value to load
//   zero      out  high when the count is zero
// ---------------------------------------------------------------------------
module beat_counter
  import grant_sequencer_pkg::*;
#(
  parameter int LW = DEFAULT_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  input  logic [LW-1:0] load_val,
  output logic          zero
);

  logic [LW-1:0] count;

  // Count register. Load wins over decrement; the decrement is gated on a
  // non-zero count so the value holds at zero instead of wrapping to all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - LW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/grant_sequencer.sv
// ---------------------------------------------------------------------------
// grant_sequencer
//
// Purpose:
//   Collects one-cycle request strobes from N clients into a registered
//   pending vector, presents that vector to an external fixed-priority
//   arbiter, and accepts the one-hot grant that comes back. An accepted
//   client owns a burst of burst_len+1 beats, after which a one-cycle done
//   pulse is raised on its bit and the sequencer returns to IDLE. Grants
//   that are not one-hot or that name a client without a pending request
//   raise a sticky protocol-error flag and are otherwise ignored.
//
// Ports:
//   clk        in   single clock, rising-edge updates
//   rst_n      in   synchronous active-low reset
//   req_set    in   [N]  per-client one-cycle request strobes
//   burst_len  in   [LW] beats minus one, sampled only on accept
//   gnt        in   [N]  one-hot grant from the external arbiter (from pend)
//   pend       out  [N]  registered pending-request vector
//   owner      out  [N]  one-hot owner of the current burst, zero when idle
//   busy       out  high exactly in state BUSY
//   done       out  [N]  one-cycle pulse on the owner bit in state DONE
//   gnt_err    out  sticky protocol-error flag
// ---------------------------------------------------------------------------
module grant_sequencer
  import grant_sequencer_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int LW = DEFAULT_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_set,
  input  logic [LW-1:0] burst_len,
  input  logic [N-1:0]  gnt,
  output logic [N-1:0]  pend,
  output logic [N-1:0]  owner,
  output logic          busy,
  output logic [N-1:0]  done,
  output logic          gnt_err
);

  seq_state_t   state;
  seq_state_t   state_next;

  logic         gnt_onehot;
  logic         gnt_pending;
  logic         gnt_valid;
  logic         gnt_invalid;

  logic         accept;
  logic         cnt_dec;
  logic         owner_clr;
  logic         err_set;
  logic         cnt_zero;
  logic [N-1:0] pend_clr;

  // Grant qualification. gnt & (gnt-1) clears the lowest set bit, so it is
  // zero only for a single-hot (or zero) vector. A valid grant must also
  // point at a client that actually has a pending request.
  assign gnt_onehot  = (gnt != '0) && ((gnt & (gnt - N'(1))) == '0);
  assign gnt_pending = ((gnt & pend) != '0);
  assign gnt_valid   = gnt_onehot && gnt_pending;
  assign gnt_invalid = (gnt != '0) && !gnt_valid;

  // The bit cleared from pend on accept is exactly the granted bit.
  assign pend_clr = accept ? gnt : '0;

  // State register. Reset forces IDLE, which also aborts any burst in
  // progress without passing through DONE, so no done pulse is produced.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode. The grant is only looked at in IDLE;
  // BUSY and DONE ignore it entirely, so a misbehaving arbiter during a
  // burst cannot raise the error flag or steal ownership.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    cnt_dec    = 1'b0;
    owner_clr  = 1'b0;
    err_set    = 1'b0;

    unique case (state)
      IDLE: begin
        if (gnt_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end else if (gnt_invalid) begin
          err_set    = 1'b1;
        end
      end

      // The counter value seen in BUSY is the number of beats still to go
      // after this one, so leaving on zero gives burst_len+1 BUSY cycles.
      BUSY: begin
        if (cnt_zero) begin
          state_next = DONE;
        end else begin
          cnt_dec    = 1'b1;
        end
      end

      DONE: begin
        owner_clr  = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pending vector, owner and error flag. The request strobe is OR-ed in
  // after the accept clear so a client re-requesting in its own accept
  // cycle keeps its pending bit. Requests seen during reset are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend    <= '0;
      owner   <= '0;
      gnt_err <= 1'b0;
    end else begin
      pend <= (pend & ~pend_clr) | req_set;

      if (accept) begin
        owner <= gnt;
      end else if (owner_clr) begin
        owner <= '0;
      end

      if (err_set) begin
        gnt_err <= 1'b1;
      end
    end
  end

  beat_counter #(
    .LW (LW)
  ) u_beat_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .dec      (cnt_dec),
    .load_val (burst_len),
    .zero     (cnt_zero)
  );

  // Status outputs are pure decodes of the state register; done mirrors
  // the owner only for the single DONE cycle.
  assign busy = (state == BUSY);
  assign done = (state == DONE) ? owner : '0;

endmodule

// File: tb/tb_grant_sequencer.sv
// ---------------------------------------------------------------------------
// tb_grant_sequencer
//
// Directed bench for grant_sequencer. A 4-bit fixed-priority arbiter model
// (lowest index wins) closes the loop from pend back to gnt; it can be
// overridden to drive illegal grants. Expected done pulses are queued when
// the stimulus is issued and a separate monitor pops and compares them
// (value and spacing) whenever the DUT raises done.
// ---------------------------------------------------------------------------
module tb_grant_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_set;
  logic [3:0] burst_len;
  logic [3:0] gnt;
  logic [3:0] pend;
  logic [3:0] owner;
  logic       busy;
  logic [3:0] done;
  logic       gnt_err;

  logic       force_en;
  logic [3:0] force_val;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int last_done_cycle = 0;

  typedef struct {
    logic [3:0] done;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  grant_sequencer #(
    .N  (4),
    .LW (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_set   (req_set),
    .burst_len (burst_len),
    .gnt       (gnt),
    .pend      (pend),
    .owner     (owner),
    .busy      (busy),
    .done      (done),
    .gnt_err   (gnt_err)
  );

  // Clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure spacing between done pulses.
  always @(posedge clk) cycle <= cycle + 1;

  // Fixed-priority arbiter model: isolate the lowest set bit of pend.
  always_comb begin
    gnt = pend & (~pend + 4'd1);
    if (force_en) gnt = force_val;
  end

  // Scoreboard monitor: every done pulse must match the next queued entry.
  always @(negedge clk) begin
    if (done != 4'b0000) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL done_unexpected: actual=%b required=no pulse", done);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (done !== mon_e.done) begin
          errors++;
          $display("[TB] FAIL done_value: actual=%b required=%b", done, mon_e.done);
        end
        if (mon_e.gap != 0) begin
          checks++;
          if ((cycle - last_done_cycle) != mon_e.gap) begin
            errors++;
            $display("[TB] FAIL done_spacing: actual=%0d required=%0d",
                     cycle - last_done_cycle, mon_e.gap);
          end
        end
      end
      last_done_cycle = cycle;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic expectDone(input logic [3:0] val, input int gap);
    exp_t e;
    e.done = val;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  // Strobe req_set for one cycle with the given burst length; returns at
  // the falling edge after the strobe has been registered.
  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] blen);
    req_set   = req;
    burst_len = blen;
    @(negedge clk);
    req_set   = 4'b0000;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    req_set   = 4'b0000;
    burst_len = 4'd0;
    force_en  = 1'b0;
    force_val = 4'b0000;

    // Reset state; requests strobed during reset are discarded.
    @(negedge clk);
    req_set = 4'b1111;
    @(negedge clk);
    req_set = 4'b0000;
    checkOutput("reset_pend",    pend,    0);
    checkOutput("reset_owner",   owner,   0);
    checkOutput("reset_busy",    busy,    0);
    checkOutput("reset_done",    done,    0);
    checkOutput("reset_gnt_err", gnt_err, 0);
    rst_n = 1'b1;
    step(1);
    checkOutput("reset_req_dropped", pend, 0);

    // Single request, burst_len=2: three BUSY cycles then DONE.
    expectDone(4'b0100, 0);
    applyStimulus(4'b0100, 4'd2);
    checkOutput("single_pend_set",    pend,  4'b0100);
    checkOutput("single_owner_idle",  owner, 4'b0000);
    checkOutput("single_busy_idle",   busy,  0);
    step(1);
    checkOutput("single_owner_acc",   owner, 4'b0100);
    checkOutput("single_pend_clr",    pend,  4'b0000);
    checkOutput("single_busy_1",      busy,  1);
    step(1);
    checkOutput("single_busy_2",      busy,  1);
    step(1);
    checkOutput("single_busy_3",      busy,  1);
    step(1);
    checkOutput("single_busy_done",   busy,  0);
    checkOutput("single_owner_done",  owner, 4'b0100);
    step(1);
    checkOutput("single_owner_clr",   owner, 4'b0000);
    checkOutput("single_done_clr",    done,  4'b0000);

    // Contention: 1011 at once, burst_len=0, serviced in priority order.
    expectDone(4'b0001, 0);
    expectDone(4'b0010, 3);
    expectDone(4'b1000, 3);
    applyStimulus(4'b1011, 4'd0);
    checkOutput("cont_pend", pend, 4'b1011);
    step(12);
    checkOutput("cont_pend_drained", pend, 4'b0000);
    checkOutput("cont_idle", busy, 0);

    // Re-request: client 0 re-requests mid-burst while client 2 waits.
    expectDone(4'b0001, 0);
    expectDone(4'b0001, 6);
    expectDone(4'b0100, 6);
    applyStimulus(4'b0101, 4'd3);
    step(1);
    checkOutput("rereq_owner_first", owner, 4'b0001);
    checkOutput("rereq_pend_first",  pend,  4'b0100);
    applyStimulus(4'b0001, 4'd3);
    step(1);
    checkOutput("rereq_pend_both",   pend,  4'b0101);
    step(4);
    checkOutput("rereq_owner_again", owner, 4'b0001);
    checkOutput("rereq_pend_left",   pend,  4'b0100);
    step(12);
    checkOutput("rereq_drained",     pend,  4'b0000);
    checkOutput("rereq_owner_idle",  owner, 4'b0000);

    // Set/clear collision on client 0 during its own accept.
    expectDone(4'b0001, 0);
    expectDone(4'b0001, 4);
    applyStimulus(4'b0001, 4'd1);
    applyStimulus(4'b0001, 4'd1);
    checkOutput("coll_pend_kept",   pend,  4'b0001);
    checkOutput("coll_owner",       owner, 4'b0001);
    step(4);
    checkOutput("coll_reaccept",    owner, 4'b0001);
    checkOutput("coll_pend_clr",    pend,  4'b0000);
    step(6);
    checkOutput("coll_gnt_err_clean", gnt_err, 0);

    // Protocol error: two-hot grant against pend=0011 in IDLE.
    force_en  = 1'b1;
    force_val = 4'b0000;
    applyStimulus(4'b0011, 4'd0);
    checkOutput("err_pend_setup", pend, 4'b0011);
    force_val = 4'b0011;
    step(1);
    checkOutput("err_flag",       gnt_err, 1);
    checkOutput("err_pend_kept",  pend,    4'b0011);
    checkOutput("err_no_owner",   owner,   4'b0000);
    checkOutput("err_no_busy",    busy,    0);
    force_val = 4'b0000;
    step(3);
    checkOutput("err_sticky",     gnt_err, 1);
    checkOutput("err_zero_gnt",   pend,    4'b0011);
    expectDone(4'b0001, 0);
    expectDone(4'b0010, 3);
    force_en = 1'b0;
    step(10);
    checkOutput("err_recover_pend", pend,  4'b0000);
    checkOutput("err_still_sticky", gnt_err, 1);

    // Reset in the middle of a burst owned by client 1.
    applyStimulus(4'b0010, 4'd5);
    step(1);
    checkOutput("rst_mid_owner", owner, 4'b0010);
    checkOutput("rst_mid_busy",  busy,  1);
    step(1);
    rst_n = 1'b0;
    step(1);
    checkOutput("rst_mid_owner_clr", owner,   4'b0000);
    checkOutput("rst_mid_busy_clr",  busy,    0);
    checkOutput("rst_mid_pend_clr",  pend,    4'b0000);
    checkOutput("rst_mid_done_clr",  done,    4'b0000);
    checkOutput("rst_mid_err_clr",   gnt_err, 0);
    rst_n = 1'b1;
    step(10);
    checkOutput("rst_mid_stay_idle", busy, 0);

    // Maximum burst length: all-ones gives 16 BUSY cycles, no wrap.
    expectDone(4'b1000, 0);
    applyStimulus(4'b1000, 4'hF);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) n++;
    end
    checkOutput("max_burst_beats", n, 16);
    checkOutput("max_burst_idle",  owner, 4'b0000);

    step(3);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grant_sequencer.md
GRANT_SEQUENCER -- requirements
Module: grant_sequencer

Interface
REQ-001 Parameter N, default 4: number of requesting clients, equal to the arbiter width.
REQ-002 Parameter LW, default 4: width of the burst-length field.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port req_set, input, N: per-client one-cycle request strobes.
REQ-006 Port burst_len, input, LW: beats minus one for the burst being accepted; sampled only on accept.
REQ-007 Port gnt, input, N: one-hot grant returned combinationally by the fixed-priority arbiter fed from pend.
REQ-008 Port pend, output, N: registered pending-request vector; drives the arbiter input.
REQ-009 Port owner, output, N: one-hot owner of the current burst; zero when idle.
REQ-010 Port busy, output, 1: high while a burst is in progress (state BUSY).
REQ-011 Port done, output, N: one-cycle pulse on the owner bit when its burst completes.
REQ-012 Port gnt_err, output, 1: sticky protocol-error flag.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE, encoded in the shared package.
REQ-014 A req_set[i] pulse SHALL set pend[i] at the next edge; a pulse on a bit already set has no effect.
REQ-015 gnt SHALL be considered only in IDLE; in BUSY and DONE it is ignored.
REQ-016 In IDLE, a valid gnt SHALL cause accept: owner<=gnt, clear the granted pend bit, counter<=burst_len, go to BUSY.
- A valid gnt is exactly one bit set, and that bit is set in pend.
REQ-017 In IDLE, an all-zero gnt SHALL keep the FSM in IDLE with no state change.
REQ-018 In IDLE, an invalid gnt SHALL set gnt_err, leave pend and owner unchanged, and keep the FSM in IDLE.
- Invalid means more than one bit set, or a bit set whose pend bit is clear.
REQ-019 In BUSY, the counter SHALL decrement once per cycle; the FSM SHALL go to DONE in the cycle after the counter reads 0.
- Burst length is therefore burst_len+1 cycles in BUSY.
REQ-020 In DONE, done SHALL equal owner for exactly one cycle, owner SHALL clear at the next edge, and the FSM SHALL return to IDLE.
REQ-021 Minimum spacing between consecutive accepts SHALL be burst_len+3 cycles: accept, BUSY beats, DONE, IDLE.
REQ-022 If req_set[i] coincides with the accept that clears pend[i], set SHALL win and pend[i] remains 1.
REQ-023 The current owner SHALL be able to re-request during BUSY or DONE; the request is arbitrated normally afterwards.
REQ-024 busy SHALL be high exactly in state BUSY; done SHALL be zero outside DONE.
REQ-025 Counter arithmetic SHALL be unsigned LW-bit; burst_len all-ones gives 2^LW beats with no wrap past zero.

Reset
REQ-026 When rst_n is low at a clock edge, the following SHALL apply at that edge:
- state<=IDLE, pend<=0, owner<=0, counter<=0, done<=0, busy<=0, gnt_err<=0.
REQ-027 Reset SHALL override a burst in progress; no done pulse is produced for the aborted burst.
REQ-028 Requests strobed while rst_n is low SHALL be discarded.

Structure
REQ-029 A shared package SHALL hold the state typedef (IDLE/BUSY/DONE) and the default N and LW constants.
REQ-030 The burst down-counter SHALL be a sub-module named beat_counter, with load, decrement and zero-flag.
REQ-031 The arbiter SHALL NOT be instantiated inside this block; gnt arrives at the port.

Verification (bench loops pend through a 4-bit fixed-priority model to gnt)
REQ-032 Single request: req_set=0100 for 1 cycle, burst_len=2 -> pend=0100, then accept (owner=0100, pend=0000), busy high 3 cycles, done=0100 for 1 cycle, owner=0000.
REQ-033 Contention: req_set=1011 in one cycle, burst_len=0 -> serviced in order 0001, 0010, 1000; each done pulse is separated by 3 cycles.
REQ-034 Re-request: client 0 pulses req_set=0001 mid-burst while client 2 is pending -> client 0 wins again after DONE, because priority 0 beats 2.
REQ-035 Protocol error: force gnt=0011 with pend=0011 in IDLE -> gnt_err=1 and stays 1, pend stays 0011, no accept.
REQ-036 Reset mid-burst: rst_n low during BUSY with owner=0010 -> next edge shows all outputs zero, no done pulse, state IDLE.
REQ-037 Set/clear collision: req_set=0001 in the same cycle client 0 is accepted -> pend[0] stays 1 and client 0 is re-accepted after DONE.
